mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage initiator for the byte-addressed, big-endian 64-byte data RAM.
- Accepts one load/store request at a time from the pipeline.
- Issues aligned 32-bit RAM read/write cycles, and does read-modify-write for byte/halfword stores.
- Returns extended load data plus an error flag for misaligned or out-of-range accesses.

Parameters:
- ADDR_LIMIT, 64, RAM size in bytes; a valid access needs addr+size_bytes <= ADDR_LIMIT.

Ports:
- CLK  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  sign-extend loads (ignored for word and stores).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal size.
- ram_address  out  32  word-aligned RAM address.
- ram_write_data  out  32  RAM write word.
- ram_read  out  1  RAM read enable.
- ram_write  out  1  RAM write enable.
- ram_data_in  in  32  RAM read data (combinational from RAM).

Behaviour:
- Reset: state IDLE; every output 0 except req_ready=1; internal data/address registers 0.
- All RAM-side outputs come from registers, so they are stable before the RAM's negedge write.
- Handshake: req_ready=1 only in IDLE. A request is accepted on a posedge with req_valid=1 in IDLE; all req_* are latched then. No back-pressure on resp.
- Checks at acceptance:
  - misaligned: halfword addr[0]!=0, word addr[1:0]!=0;
  - req_size=11;
  - addr+bytes > ADDR_LIMIT (computed 33-bit, no wrap).
  - Any failure -> ERR.
- States:
  - IDLE: on accept -> ERR, RD (load or sub-word store) or WR (word store).
  - RD (1 cycle): ram_address={addr[31:2],2'b00}, ram_read=1. ram_data_in captured at the closing posedge. Load -> RESP; store -> WR.
  - WR (1 cycle): ram_write=1, ram_address aligned, ram_write_data as follows.
    - Word store: req_wdata.
    - Byte store: captured word with lane replaced by wdata[7:0]. Offsets 0/1/2/3 map to bits [31:24]/[23:16]/[15:8]/[7:0].
    - Halfword store: offset 0 -> [31:16], offset 2 -> [15:0].
    - The RAM commits on the negedge inside WR. -> RESP.
  - RESP: resp_valid=1, resp_err=0. resp_rdata holds the selected lane, zero- or sign-extended per the latched req_signed (word unmodified). ram_read/ram_write=0. -> IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0. No RAM activity at all. -> IDLE.
- Latency from accept edge: load 2 cycles to resp_valid; word store 2; sub-word store 3; error 1. Next accept possible one cycle after RESP/ERR.
- Outside RD, ram_read=0; outside WR, ram_write=0 and ram_write_data=0.
- Reset mid-operation: at the posedge, state -> IDLE and outputs cleared. A WR cycle already in progress has already committed at its negedge; a store reset during RD writes nothing. No resp is issued for the aborted request.
- req_valid while busy is ignored; it is not queued.

Optional Feature:
- Macro MEM_STAT_EN.
- Defined: adds outputs load_count (16) and store_count (16). Each increments on RESP of a successful load/store, saturates at 16'hFFFF, and is cleared by Reset. Error responses are not counted.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Word store addr=0x08 data=0x11223344, then word load 0x08 -> RAM bytes 8..11 = 11,22,33,44; load resp_rdata=0x11223344, resp_valid 2 cycles after accept.
- Byte store addr=0x09 data=0xAB over that word -> RD then WR, written word 0x11AB3344. Signed byte load 0x09 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Halfword store 0x0A data=0x8001, then signed halfword load 0x0A -> 0xFFFF8001; unsigned -> 0x00008001; bytes 8,9 unchanged.
- Word load 0x06, halfword store 0x03, word load 0x3E (ADDR_LIMIT=64), req_size=11 -> each resp_err=1 one cycle after accept, rdata=0, ram_read/ram_write never asserted.
- Reset asserted during RD of a byte store to 0x10 -> no ram_write, no resp_valid, req_ready=1 next cycle, RAM byte 0x10 unchanged.
- MEM_STAT_EN: 3 loads, 2 stores, 1 error -> load_count=3, store_count=2; Reset -> both 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator for a big-endian byte-addressed data RAM.
// Optional MEM_STAT_EN adds saturating load/store completion counters.
module mem_access_ctrl #(
    parameter int ADDR_LIMIT = 64
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_address,
    output logic [31:0] ram_write_data,
    output logic        ram_read,
    output logic        ram_write,
    input  logic [31:0] ram_data_in
`ifdef MEM_STAT_EN
   ,output logic [15:0] load_count,
    output logic [15:0] store_count
`endif
);

    typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;

    state_t      state, state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        signed_q;
    logic [15:0] wdata_q;

    logic        req_ready_d, resp_valid_d, resp_err_d, ram_read_d, ram_write_d;
    logic [31:0] resp_rdata_d, ram_address_d, ram_write_data_d;

    logic [2:0]  nbytes;
    logic [32:0] end_addr;
    logic        misaligned, bad_req;

    // Big-endian lanes: offset 0 is the most significant byte, so the bit
    // base of a lane is 8*(3-off), which for two bits is just {~off,3'b0}.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic [15:0] d);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00)
            r[{~off, 3'b000} +: 8] = d[7:0];
        else
            r[{~off[1], 4'b0000} +: 16] = d;
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{~off, 3'b000} +: 8];
        h = w[{~off[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    always_comb begin
        case (req_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        end_addr   = {1'b0, req_addr} + {30'b0, nbytes};
        misaligned = (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        bad_req    = misaligned || (req_size == 2'b11) || (end_addr > 33'(ADDR_LIMIT));
    end

    // Outputs are computed for the state being entered and registered, so
    // the RAM sees stable address/data for the whole RD/WR cycle.
    always_comb begin
        state_d          = state;
        resp_valid_d     = 1'b0;
        resp_err_d       = 1'b0;
        resp_rdata_d     = 32'h0;
        ram_read_d       = 1'b0;
        ram_write_d      = 1'b0;
        ram_address_d    = 32'h0;
        ram_write_data_d = 32'h0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad_req) begin
                        state_d      = ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_write || req_size != 2'b10) begin
                        state_d       = RD;
                        ram_read_d    = 1'b1;
                        ram_address_d = {req_addr[31:2], 2'b00};
                    end else begin
                        state_d          = WR;
                        ram_write_d      = 1'b1;
                        ram_address_d    = {req_addr[31:2], 2'b00};
                        ram_write_data_d = req_wdata;
                    end
                end
            end
            RD: begin
                if (write_q) begin
                    state_d          = WR;
                    ram_write_d      = 1'b1;
                    ram_address_d    = {addr_q[31:2], 2'b00};
                    ram_write_data_d = merge(ram_data_in, addr_q[1:0], size_q, wdata_q);
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = extract(ram_data_in, addr_q[1:0], size_q, signed_q);
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state          <= IDLE;
            addr_q         <= 32'h0;
            size_q         <= 2'b00;
            write_q        <= 1'b0;
            signed_q       <= 1'b0;
            wdata_q        <= 16'h0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= 32'h0;
            ram_read       <= 1'b0;
            ram_write      <= 1'b0;
            ram_address    <= 32'h0;
            ram_write_data <= 32'h0;
        end else begin
            state          <= state_d;
            req_ready      <= req_ready_d;
            resp_valid     <= resp_valid_d;
            resp_err       <= resp_err_d;
            resp_rdata     <= resp_rdata_d;
            ram_read       <= ram_read_d;
            ram_write      <= ram_write_d;
            ram_address    <= ram_address_d;
            ram_write_data <= ram_write_data_d;
            if (state == IDLE && req_valid) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                write_q  <= req_write;
                signed_q <= req_signed;
                wdata_q  <= req_wdata[15:0];
            end
        end
    end

`ifdef MEM_STAT_EN
    always_ff @(posedge CLK) begin
        if (Reset) begin
            load_count  <= 16'h0;
            store_count <= 16'h0;
        end else if (state == RESP) begin
            if (write_q && store_count != 16'hFFFF)
                store_count <= store_count + 16'd1;
            else if (!write_q && load_count != 16'hFFFF)
                load_count <= load_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed table-driven bench for mem_access_ctrl with a big-endian RAM model.
module tb_mem_access_ctrl;

    logic        CLK, Reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] ram_address, ram_write_data, ram_data_in;
    logic        ram_read, ram_write;
`ifdef MEM_STAT_EN
    logic [15:0] load_count, store_count;
`endif

    mem_access_ctrl #(.ADDR_LIMIT(64)) dut (
        .CLK(CLK), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_read(ram_read),
        .ram_write(ram_write), .ram_data_in(ram_data_in)
`ifdef MEM_STAT_EN
       ,.load_count(load_count), .store_count(store_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Big-endian byte RAM: combinational read, commits on negedge.
    logic [7:0] mem [0:63];
    logic [5:0] ba;
    always_comb begin
        ba          = {ram_address[5:2], 2'b00};
        ram_data_in = {mem[ba], mem[ba + 6'd1], mem[ba + 6'd2], mem[ba + 6'd3]};
    end
    always @(negedge CLK) begin
        if (ram_write) begin
            mem[ba]        <= ram_write_data[31:24];
            mem[ba + 6'd1] <= ram_write_data[23:16];
            mem[ba + 6'd2] <= ram_write_data[15:8];
            mem[ba + 6'd3] <= ram_write_data[7:0];
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic        rd_seen;
        logic        wr_seen;
    } vec_t;

    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

    int total = 0;
    int bad   = 0;
    int exp_loads = 0, exp_stores = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic err, input logic [31:0] rdata, input int lat,
                                input logic rs, input logic ws);
        vec_t v;
        v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wdata = wdata;
        v.err = err; v.rdata = rdata; v.lat = lat; v.rd_seen = rs; v.wr_seen = ws;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge CLK);
        while (!req_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready) chk({name, "_ready_timeout"}, 32'(req_ready), 32'h1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        logic rs, ws;
        string nm;
        nm = $sformatf("vec%0d", idx);
        wait_ready(nm);
        req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_signed = v.sg;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        lat = 1; rs = ram_read; ws = ram_write;
        while (!resp_valid && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
            rs |= ram_read; ws |= ram_write;
        end
        chk({nm, "_resp_valid"}, 32'(resp_valid), 32'h1);
        chk({nm, "_latency"},    32'(lat),        32'(v.lat));
        chk({nm, "_err"},        32'(resp_err),   32'(v.err));
        chk({nm, "_rdata"},      resp_rdata,      v.rdata);
        chk({nm, "_ram_read"},   32'(rs),         32'(v.rd_seen));
        chk({nm, "_ram_write"},  32'(ws),         32'(v.wr_seen));
    endtask

    initial begin
        logic seen;
        req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0;

        //            wr  size sg addr           wdata         err rdata          lat rd wr
        tbl.push_back(mk(1, SW, 0, 32'h08, 32'h11223344, 0, 32'h0,        2, 0, 1));
        tbl.push_back(mk(0, SW, 0, 32'h08, 32'h0,        0, 32'h11223344, 2, 1, 0));
        tbl.push_back(mk(1, SB, 0, 32'h09, 32'h123456AB, 0, 32'h0,        3, 1, 1));
        tbl.push_back(mk(0, SB, 1, 32'h09, 32'h0,        0, 32'hFFFFFFAB, 2, 1, 0));
        tbl.push_back(mk(0, SB, 0, 32'h09, 32'h0,        0, 32'h000000AB, 2, 1, 0));
        tbl.push_back(mk(0, SW, 0, 32'h08, 32'h0,        0, 32'h11AB3344, 2, 1, 0));
        tbl.push_back(mk(1, SH, 0, 32'h0A, 32'hDEAD8001, 0, 32'h0,        3, 1, 1));
        tbl.push_back(mk(0, SH, 1, 32'h0A, 32'h0,        0, 32'hFFFF8001, 2, 1, 0));
        tbl.push_back(mk(0, SH, 0, 32'h0A, 32'h0,        0, 32'h00008001, 2, 1, 0));
        tbl.push_back(mk(0, SW, 0, 32'h08, 32'h0,        0, 32'h11AB8001, 2, 1, 0));
        tbl.push_back(mk(0, SB, 1, 32'h0B, 32'h0,        0, 32'h00000001, 2, 1, 0));
        tbl.push_back(mk(0, SB, 1, 32'h0A, 32'h0,        0, 32'hFFFFFF80, 2, 1, 0));
        tbl.push_back(mk(0, SB, 0, 32'h08, 32'h0,        0, 32'h00000011, 2, 1, 0));
        tbl.push_back(mk(1, SH, 0, 32'h08, 32'h00007FFE, 0, 32'h0,        3, 1, 1));
        tbl.push_back(mk(0, SH, 1, 32'h08, 32'h0,        0, 32'h00007FFE, 2, 1, 0));
        tbl.push_back(mk(1, SB, 0, 32'h0B, 32'h000000CC, 0, 32'h0,        3, 1, 1));
        tbl.push_back(mk(0, SW, 1, 32'h08, 32'h0,        0, 32'h7FFE80CC, 2, 1, 0));
        tbl.push_back(mk(1, SW, 0, 32'h3C, 32'hCAFEF00D, 0, 32'h0,        2, 0, 1));
        tbl.push_back(mk(0, SW, 0, 32'h3C, 32'h0,        0, 32'hCAFEF00D, 2, 1, 0));
        tbl.push_back(mk(0, SB, 0, 32'h3F, 32'h0,        0, 32'h0000000D, 2, 1, 0));
        tbl.push_back(mk(0, SH, 1, 32'h3E, 32'h0,        0, 32'hFFFFF00D, 2, 1, 0));
        tbl.push_back(mk(1, SW, 0, 32'h10, 32'h5A000000, 0, 32'h0,        2, 0, 1));
        tbl.push_back(mk(0, SW, 0, 32'h06, 32'h0,        1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(1, SH, 0, 32'h03, 32'h1234,     1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, SW, 0, 32'h3E, 32'h0,        1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, SX, 0, 32'h00, 32'h0,        1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, SW, 0, 32'h40, 32'h0,        1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, SB, 0, 32'h40, 32'h0,        1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(1, SB, 0, 32'h40, 32'hFF,       1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, SW, 0, 32'hFFFFFFFC, 32'h0,  1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, SH, 0, 32'h3F, 32'h0,        1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, SW, 0, 32'h08, 32'h0,        0, 32'h7FFE80CC, 2, 1, 0));

        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_req_ready",  32'(req_ready),  32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_err",   32'(resp_err),   32'h0);
        chk("rst_resp_rdata", resp_rdata,      32'h0);
        chk("rst_ram_rw",     {30'h0, ram_read, ram_write}, 32'h0);
        chk("rst_ram_addr",   ram_address,     32'h0);
        chk("rst_ram_wdata",  ram_write_data,  32'h0);
        @(negedge CLK);
        Reset = 1'b0;

        foreach (tbl[i]) begin
            run_vec(tbl[i], i);
            if (!tbl[i].err) begin
                if (tbl[i].wr) exp_stores++;
                else           exp_loads++;
            end
        end

        chk("mem_word8",  {mem[8], mem[9], mem[10], mem[11]},     32'h7FFE80CC);
        chk("mem_word60", {mem[60], mem[61], mem[62], mem[63]},   32'hCAFEF00D);
`ifdef MEM_STAT_EN
        chk("load_count",  32'(load_count),  32'(exp_loads));
        chk("store_count", 32'(store_count), 32'(exp_stores));
`endif

        // Reset during the RD cycle of a byte store: nothing written, no resp.
        wait_ready("rst_mid");
        req_valid = 1'b1; req_write = 1'b1; req_size = SB; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h77;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        chk("rst_mid_in_rd", 32'(ram_read), 32'h1);
        seen = ram_write;
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK); #1;
        chk("rst_mid_ready",  32'(req_ready),  32'h1);
        chk("rst_mid_noresp", 32'(resp_valid), 32'h0);
        chk("rst_mid_rd_off", 32'(ram_read),   32'h0);
`ifdef MEM_STAT_EN
        chk("rst_load_count",  32'(load_count),  32'h0);
        chk("rst_store_count", 32'(store_count), 32'h0);
`endif
        @(negedge CLK);
        Reset = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
            seen |= ram_write | resp_valid;
        end
        chk("rst_mid_quiet", 32'(seen), 32'h0);
        chk("rst_mid_byte10", 32'(mem[16]), 32'h5A);
        run_vec(mk(0, SW, 0, 32'h10, 32'h0, 0, 32'h5A000000, 2, 1, 0), 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
